i8085_system: RTL and testbench
===============================

Name: i8085_system

Overview:
- Self-contained, minimal 8085-style computer: one 8-bit CPU core (instance U1) plus internal 256x8 memory on a shared bus.
- The address space is reduced to 8 bits.
- Only clk and rst are driven; everything else is an observation output used by simulation benches and waveform debug.
- The CPU exposes internal register data_in (last byte read from the bus); benches probe it hierarchically as U1.data_in.

Parameters:
- MEM_DEPTH, 256, memory words (address width fixed at 8).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- s0  out  1  status bit 0
- s1  out  1  status bit 1
- io_mn  out  1  IO/memory select, always 0 (memory only)
- ale  out  1  address latch enable, high in T1
- rd_n  out  1  read strobe, active low
- wr_n  out  1  write strobe, active low
- addr  out  8  bus address
- data  out  8  bus data value (memory read data or CPU write data)
- state  out  2  00=T1, 01=T2, 10=T3, 11=halted

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (rst=1 at a rising edge):
  - PC=00, A=B=00, flags Z=S=CY=0, data_in=00, state=T1.
  - Next machine cycle is an opcode fetch.
  - Outputs: ale=1, rd_n=wr_n=1, addr=00, s1s0=11, io_mn=0.
  - Memory contents are not cleared by reset.
  - Reset mid-cycle aborts the cycle; no write occurs on that edge.
- Machine cycle is 3 clocks, T1 -> T2 -> T3.
  - T1: ale=1, addr driven, strobes high.
  - T2: rd_n=0 (read) or wr_n=0 (write).
  - T3: strobes high, execute/advance.
- Status s1,s0: opcode fetch 11, memory read 10, memory write 01, halt 00.
- Memory read is combinational from addr.
- data_in latches the bus data on the edge ending T2 of every read or fetch cycle; it holds between reads.
- Memory write commits on the edge ending T2 of a write cycle, using data = A.
- PC increments after each fetch and each operand read; it wraps FF -> 00.
- Instruction results update on the edge ending the last T3 of the instruction.
- Instruction set (unlisted opcodes execute as NOP):
  - 00 NOP: fetch only.
  - 3E n MVI A,n; 06 n MVI B,n: fetch + read.
  - 78 MOV A,B: fetch.
  - 80 ADD B; 90 SUB B: fetch. A = A±B mod 256. CY = carry out / borrow. Z = (A==0), S = A[7].
  - 3C INR A; 3D DCR A: fetch. Wraps mod 256. Updates Z, S; CY unchanged.
  - 32 a STA a: fetch, read a, write mem[a]=A.
  - 3A a LDA a: fetch, read a, read mem[a] into A.
  - C3 a JMP a: fetch, read a, then PC=a.
  - 76 HLT: fetch, then state=11, s1s0=00, strobes high, ale=0. Held until reset.
- Default program, loaded at time zero: 00:3E 05, 02:06 03, 04:80, 05:32 20, 07:76. All other locations are 00.

Optional Feature:
- MEM_INIT_FILE_EN defined: memory is initialised from hex file "program.hex" ($readmemh) instead of the default program.
- Undefined: the built-in default program is used.

Test Plan:
- Reset held 2 cycles -> state=00, addr=00, ale=1, rd_n=wr_n=1, s1s0=11, U1.data_in=00.
- Run default program:
  - U1.data_in sequence is 3E,05,06,03,80,32,20,76.
  - After HLT, mem[20]=08, A=08, Z=0, CY=0, state=11.
  - The halt state is reached 27 clocks after reset release.
- STA write cycle -> in T2, addr=20, wr_n=0, data=08, s1s0=01; rd_n stays 1.
- Program 3E FF,3C,76 -> A=00, Z=1, CY=0. Program 3E 00,06 01,90,76 -> A=FF, CY=1, S=1.
- Program C3 10 at 00; 10:3E 07,76 -> A=07; address 02 never fetched.
- Assert rst during T2 of the STA write -> no memory write; restart at PC=00 with T1 on the next cycle.

Source files
------------

// File: rtl/i8085_system.sv
// i8085_system: minimal 8085-style computer, CPU core U1 plus 256x8 memory.
// Memory starts from the built-in default program.

module i8085_core (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] mem_rdata,
    output logic [1:0] status,
    output logic       ale,
    output logic       rd_n,
    output logic       wr_n,
    output logic [7:0] addr,
    output logic [7:0] data,
    output logic [1:0] state
);
    typedef enum logic [1:0] {
        T1   = 2'b00,
        T2   = 2'b01,
        T3   = 2'b10,
        HALT = 2'b11
    } tstate_t;

    typedef enum logic [1:0] {
        CYC_FETCH,
        CYC_OPR,
        CYC_MRD,
        CYC_MWR
    } cyc_t;

    localparam logic [7:0] OP_MVI_A = 8'h3E;
    localparam logic [7:0] OP_MVI_B = 8'h06;
    localparam logic [7:0] OP_MOV_AB = 8'h78;
    localparam logic [7:0] OP_ADD_B = 8'h80;
    localparam logic [7:0] OP_SUB_B = 8'h90;
    localparam logic [7:0] OP_INR_A = 8'h3C;
    localparam logic [7:0] OP_DCR_A = 8'h3D;
    localparam logic [7:0] OP_STA = 8'h32;
    localparam logic [7:0] OP_LDA = 8'h3A;
    localparam logic [7:0] OP_JMP = 8'hC3;
    localparam logic [7:0] OP_HLT = 8'h76;

    tstate_t    ts;
    cyc_t       cyc;
    logic [7:0] pc;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] ir;
    logic [7:0] data_in;
    logic       z;
    logic       s;
    logic       cy;

    cyc_t       nxt_cyc;
    logic [7:0] nxt_pc;
    logic [7:0] nxt_addr;
    logic       nxt_halt;
    logic [1:0] nxt_status;
    logic [7:0] pc_inc;
    logic [8:0] sum9;
    logic [8:0] dif9;
    logic [7:0] inc8;
    logic [7:0] dec8;

    assign pc_inc = pc + 8'd1;
    assign sum9   = {1'b0, a} + {1'b0, b};
    assign dif9   = {1'b0, a} - {1'b0, b};
    assign inc8   = a + 8'd1;
    assign dec8   = a - 8'd1;
    assign state  = ts;
    assign data   = (cyc == CYC_MWR) ? a : mem_rdata;

    // Sequencing: pick the next machine cycle, its address and the new PC at T3
    always_comb begin
        nxt_cyc    = CYC_FETCH;
        nxt_pc     = pc;
        nxt_addr   = pc;
        nxt_halt   = 1'b0;
        nxt_status = 2'b11;
        unique case (cyc)
            CYC_FETCH: begin
                nxt_pc   = pc_inc;
                nxt_addr = pc_inc;
                case (data_in)
                    OP_MVI_A, OP_MVI_B, OP_STA,
                    OP_LDA, OP_JMP: nxt_cyc = CYC_OPR;
                    OP_HLT: nxt_halt = 1'b1;
                    default: ;
                endcase
            end
            CYC_OPR: begin
                nxt_pc   = pc_inc;
                nxt_addr = pc_inc;
                case (ir)
                    OP_STA: begin
                        nxt_cyc  = CYC_MWR;
                        nxt_addr = data_in;
                    end
                    OP_LDA: begin
                        nxt_cyc  = CYC_MRD;
                        nxt_addr = data_in;
                    end
                    OP_JMP: begin
                        nxt_pc   = data_in;
                        nxt_addr = data_in;
                    end
                    default: ;
                endcase
            end
            CYC_MRD, CYC_MWR: ;
        endcase
        unique case (nxt_cyc)
            CYC_FETCH: nxt_status = 2'b11;
            CYC_OPR, CYC_MRD: nxt_status = 2'b10;
            CYC_MWR: nxt_status = 2'b01;
        endcase
        if (nxt_halt) begin
            nxt_status = 2'b00;
        end
    end

    // T-state machine with registered bus outputs; instructions retire at the last T3
    always_ff @(posedge clk) begin
        if (rst) begin
            ts      <= T1;
            cyc     <= CYC_FETCH;
            pc      <= 8'h00;
            a       <= 8'h00;
            b       <= 8'h00;
            ir      <= 8'h00;
            data_in <= 8'h00;
            z       <= 1'b0;
            s       <= 1'b0;
            cy      <= 1'b0;
            ale     <= 1'b1;
            rd_n    <= 1'b1;
            wr_n    <= 1'b1;
            addr    <= 8'h00;
            status  <= 2'b11;
        end else begin
            unique case (ts)
                T1: begin
                    ts  <= T2;
                    ale <= 1'b0;
                    if (cyc == CYC_MWR) begin
                        wr_n <= 1'b0;
                    end else begin
                        rd_n <= 1'b0;
                    end
                end
                T2: begin
                    ts   <= T3;
                    rd_n <= 1'b1;
                    wr_n <= 1'b1;
                    if (cyc != CYC_MWR) begin
                        data_in <= mem_rdata;
                    end
                end
                T3: begin
                    ts     <= nxt_halt ? HALT : T1;
                    ale    <= ~nxt_halt;
                    cyc    <= nxt_cyc;
                    addr   <= nxt_addr;
                    status <= nxt_status;
                    pc     <= nxt_pc;
                    unique case (cyc)
                        CYC_FETCH: begin
                            ir <= data_in;
                            case (data_in)
                                OP_MOV_AB: a <= b;
                                OP_ADD_B: begin
                                    a  <= sum9[7:0];
                                    cy <= sum9[8];
                                    z  <= (sum9[7:0] == 8'h00);
                                    s  <= sum9[7];
                                end
                                OP_SUB_B: begin
                                    a  <= dif9[7:0];
                                    cy <= dif9[8];
                                    z  <= (dif9[7:0] == 8'h00);
                                    s  <= dif9[7];
                                end
                                OP_INR_A: begin
                                    a <= inc8;
                                    z <= (inc8 == 8'h00);
                                    s <= inc8[7];
                                end
                                OP_DCR_A: begin
                                    a <= dec8;
                                    z <= (dec8 == 8'h00);
                                    s <= dec8[7];
                                end
                                default: ;
                            endcase
                        end
                        CYC_OPR: begin
                            case (ir)
                                OP_MVI_A: a <= data_in;
                                OP_MVI_B: b <= data_in;
                                default: ;
                            endcase
                        end
                        CYC_MRD: a <= data_in;
                        CYC_MWR: ;
                    endcase
                end
                HALT: begin
                    ts <= HALT;
                end
            endcase
        end
    end
endmodule

module i8085_system #(
    parameter int MEM_DEPTH = 256
) (
    input  logic       clk,
    input  logic       rst,
    output logic       s0,
    output logic       s1,
    output logic       io_mn,
    output logic       ale,
    output logic       rd_n,
    output logic       wr_n,
    output logic [7:0] addr,
    output logic [7:0] data,
    output logic [1:0] state
);
    logic [1:0] status;
    logic [7:0] mem_rdata;

    logic [7:0] mem [MEM_DEPTH] = '{
        0: 8'h3E, 1: 8'h05, 2: 8'h06, 3: 8'h03,
        4: 8'h80, 5: 8'h32, 6: 8'h20, 7: 8'h76,
        default: 8'h00
    };

    assign mem_rdata = mem[addr];
    assign io_mn     = 1'b0;
    assign s1        = status[1];
    assign s0        = status[0];

    // Memory write commits at the edge ending T2; a reset on that edge aborts it
    always_ff @(posedge clk) begin
        if (!rst && !wr_n) begin
            mem[addr] <= data;
        end
    end

    i8085_core U1 (
        .clk       (clk),
        .rst       (rst),
        .mem_rdata (mem_rdata),
        .status    (status),
        .ale       (ale),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .addr      (addr),
        .data      (data),
        .state     (state)
    );
endmodule

// File: tb/tb_i8085_system.sv
// tb_i8085_system: directed bench for the i8085_system computer.
// Programs are loaded into dut.mem while reset is held.

module tb_i8085_system;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s0;
    logic       s1;
    logic       io_mn;
    logic       ale;
    logic       rd_n;
    logic       wr_n;
    logic [7:0] addr;
    logic [7:0] data;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    logic [7:0] seen [$];
    int         cyc_count;
    bit         fetched02;
    bit         wr_seen;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [1:0] wr_st;
    logic       wr_rd;

    i8085_system dut (
        .clk   (clk),
        .rst   (rst),
        .s0    (s0),
        .s1    (s1),
        .io_mn (io_mn),
        .ale   (ale),
        .rd_n  (rd_n),
        .wr_n  (wr_n),
        .addr  (addr),
        .data  (data),
        .state (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic poke(input int a, input logic [7:0] v);
        dut.mem[a] <= v;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) dut.mem[i] <= 8'h00;
    endtask

    task automatic load_default();
        clear_mem();
        poke(0, 8'h3E); poke(1, 8'h05);
        poke(2, 8'h06); poke(3, 8'h03);
        poke(4, 8'h80); poke(5, 8'h32);
        poke(6, 8'h20); poke(7, 8'h76);
    endtask

    task automatic hold_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run(input int limit);
        seen.delete();
        cyc_count = 0;
        fetched02 = 1'b0;
        wr_seen   = 1'b0;
        while (cyc_count < limit) begin
            @(posedge clk);
            #1;
            cyc_count++;
            if (state == 2'b10 && {s1, s0} != 2'b01)
                seen.push_back(dut.U1.data_in);
            if (ale && {s1, s0} == 2'b11 && addr == 8'h02)
                fetched02 = 1'b1;
            if (!wr_n && !wr_seen) begin
                wr_seen = 1'b1;
                wr_addr = addr;
                wr_data = data;
                wr_st   = {s1, s0};
                wr_rd   = rd_n;
            end
            if (state == 2'b11) break;
        end
        check("halt_reached", state, 2'b11);
    endtask

    logic [7:0] exp_seq [8] = '{8'h3E, 8'h05, 8'h06, 8'h03,
                                8'h80, 8'h32, 8'h20, 8'h76};

    initial begin
        int n;
        bit found;

        rst = 1'b1;
        hold_reset();
        check("rst_state", state, 2'b00);
        check("rst_addr", addr, 8'h00);
        check("rst_ale", ale, 1'b1);
        check("rst_rd_n", rd_n, 1'b1);
        check("rst_wr_n", wr_n, 1'b1);
        check("rst_status", {s1, s0}, 2'b11);
        check("rst_io_mn", io_mn, 1'b0);
        check("rst_data_in", dut.U1.data_in, 8'h00);

        rst = 1'b0;
        run(60);
        check("halt_clocks", cyc_count, 27);
        check("seq_len", seen.size(), 8);
        n = (seen.size() < 8) ? seen.size() : 8;
        for (int i = 0; i < n; i++)
            check($sformatf("seq%0d", i), seen[i], exp_seq[i]);
        check("dflt_mem20", dut.mem[8'h20], 8'h08);
        check("dflt_a", dut.U1.a, 8'h08);
        check("dflt_z", dut.U1.z, 1'b0);
        check("dflt_cy", dut.U1.cy, 1'b0);
        check("halt_status", {s1, s0}, 2'b00);
        check("halt_ale", ale, 1'b0);
        check("halt_strobes", {rd_n, wr_n}, 2'b11);
        check("sta_seen", wr_seen, 1'b1);
        check("sta_addr", wr_addr, 8'h20);
        check("sta_data", wr_data, 8'h08);
        check("sta_status", wr_st, 2'b01);
        check("sta_rd_n", wr_rd, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("halt_hold", state, 2'b11);

        rst = 1'b1;
        clear_mem();
        poke(0, 8'h3E); poke(1, 8'hFF);
        poke(2, 8'h3C); poke(3, 8'h76);
        hold_reset();
        rst = 1'b0;
        run(60);
        check("inr_a", dut.U1.a, 8'h00);
        check("inr_z", dut.U1.z, 1'b1);
        check("inr_cy", dut.U1.cy, 1'b0);
        check("inr_s", dut.U1.s, 1'b0);

        rst = 1'b1;
        clear_mem();
        poke(0, 8'h3E); poke(1, 8'h00);
        poke(2, 8'h06); poke(3, 8'h01);
        poke(4, 8'h90); poke(5, 8'h76);
        hold_reset();
        rst = 1'b0;
        run(60);
        check("sub_a", dut.U1.a, 8'hFF);
        check("sub_cy", dut.U1.cy, 1'b1);
        check("sub_s", dut.U1.s, 1'b1);
        check("sub_z", dut.U1.z, 1'b0);

        rst = 1'b1;
        clear_mem();
        poke(0, 8'hC3); poke(1, 8'h10);
        poke(8'h10, 8'h3E); poke(8'h11, 8'h07);
        poke(8'h12, 8'h76);
        hold_reset();
        rst = 1'b0;
        run(60);
        check("jmp_a", dut.U1.a, 8'h07);
        check("jmp_skip02", fetched02, 1'b0);

        rst = 1'b1;
        load_default();
        hold_reset();
        rst = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (!wr_n) begin
                found = 1'b1;
                break;
            end
        end
        check("abort_found_t2", found, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_mem20", dut.mem[8'h20], 8'h00);
        check("abort_state", state, 2'b00);
        check("abort_addr", addr, 8'h00);
        check("abort_ale", ale, 1'b1);
        check("abort_status", {s1, s0}, 2'b11);
        check("abort_wr_n", wr_n, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("restart_t2", state, 2'b01);
        check("restart_rd_n", rd_n, 1'b0);
        check("restart_addr", addr, 8'h00);
        run(60);
        check("restart_mem20", dut.mem[8'h20], 8'h08);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
